// File: rtl/flood_pkg.sv
// Shared Flood-It definitions: board limits, colour type/encoding and engine FSM states.
// Imported by the board engine, its LFSR and the display stage.
package flood_pkg;

  localparam int          MAX_SIZE   = 26;
  localparam int          NUM_COLORS = 6;
  localparam int          MAX_MOVES  = 25;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef logic [2:0] color_t;

  // Colour code meaning shared with the VGA palette.
  typedef enum logic [2:0] {
    C_RED     = 3'd0,
    C_GREEN   = 3'd1,
    C_BLUE    = 3'd2,
    C_YELLOW  = 3'd3,
    C_MAGENTA = 3'd4,
    C_CYAN    = 3'd5,
    C_ORANGE  = 3'd6,
    C_WHITE   = 3'd7
  } color_name_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_GROW    = 3'd2,
    ST_READY   = 3'd3,
    ST_RECOLOR = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  // Folds a raw 3-bit random value into 0..num_colors-1.
  function automatic color_t wrap_color(input logic [2:0] raw, input int num_colors);
    if (int'(raw) >= num_colors) return raw - 3'(num_colors);
    return raw;
  endfunction

endpackage

// File: rtl/flood_lfsr16.sv
// 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting right.
// load takes priority over step.
module flood_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);
  import flood_pkg::*;

  logic [15:0] value_next;

  assign value_next = {1'b0, value[15:1]} ^ (value[0] ? 16'hB400 : 16'h0000);

  always_ff @(posedge CLOCK) begin
    if (RESET)     value <= SEED;
    else if (load) value <= seed;
    else if (step) value <= value_next;
  end

endmodule

// File: rtl/flood_board_engine.sv
// Flood-It game-state engine: owns the board, builds random boards, applies colour moves,
// grows the flooded region with row-major scan passes and flags win/loss.
module flood_board_engine #(
  parameter int          MAX_SIZE   = flood_pkg::MAX_SIZE,
  parameter int          NUM_COLORS = flood_pkg::NUM_COLORS,
  parameter int          MAX_MOVES  = flood_pkg::MAX_MOVES,
  parameter logic [15:0] LFSR_SEED  = flood_pkg::LFSR_SEED
) (
  input  logic                                         CLOCK,
  input  logic                                         RESET,
  input  logic                                         start,
  input  logic [4:0]                                   size_in,
  input  logic [15:0]                                  seed_in,
  input  logic                                         color_valid,
  input  logic [2:0]                                   color_sel,
  output flood_pkg::color_t [MAX_SIZE-1:0][MAX_SIZE-1:0] BOARD,
  output logic [4:0]                                   SIZE,
  output logic                                         initialized,
  output logic                                         busy,
  output logic [4:0]                                   move_count,
  output logic                                         won,
  output logic                                         lost,
  output flood_pkg::state_t                            dbg_state,
  output logic [MAX_SIZE-1:0][MAX_SIZE-1:0]            dbg_mask
);
  import flood_pkg::*;

  // Handshake: start and color_valid are single-cycle pulses with no ready; a pulse that
  // arrives while the engine cannot take it (busy, OVER, invalid colour) is dropped.

  state_t                            state, state_next;
  logic [MAX_SIZE-1:0][MAX_SIZE-1:0] mask;
  logic [4:0]                        row, col;
  logic [9:0]                        pop_count;
  logic [9:0]                        size_sq;
  logic                              changed;
  color_t                            move_color;
  logic [4:0]                        size_clamped;
  logic [15:0]                       seed_sel;
  logic [15:0]                       lfsr_value;
  logic                              lfsr_load, lfsr_step;
  color_t                            fill_color, region_color;
  logic                              last_cell, nb_hit, join_now, pass_changed;
  logic                              grow_done, full, moves_spent, move_ok;
  logic                              unused_lfsr_bits;

  assign seed_sel         = (seed_in == 16'h0000) ? LFSR_SEED : seed_in;
  assign fill_color       = wrap_color(lfsr_value[2:0], NUM_COLORS);
  assign unused_lfsr_bits = ^lfsr_value[15:3];

  flood_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .load  (lfsr_load),
    .step  (lfsr_step),
    .seed  (seed_sel),
    .value (lfsr_value)
  );

  always_comb begin
    if (size_in < 5'd2)                size_clamped = 5'd2;
    else if (int'(size_in) > MAX_SIZE) size_clamped = 5'(MAX_SIZE);
    else                               size_clamped = size_in;
  end

  assign region_color = BOARD[0][0];
  assign last_cell    = (row == SIZE - 5'd1) && (col == SIZE - 5'd1);
  assign size_sq      = 10'(SIZE) * 10'(SIZE);
  assign full         = (pop_count == size_sq);
  assign moves_spent  = (move_count == 5'(MAX_MOVES));
  assign move_ok      = color_valid && ({1'b0, color_sel} < 4'(NUM_COLORS)) &&
                        (color_sel != region_color);

  // Neighbours come from the live mask, so joins earlier in this pass propagate forward.
  always_comb begin
    nb_hit = 1'b0;
    if (row != 5'd0)        nb_hit = nb_hit | mask[row - 5'd1][col];
    if (row + 5'd1 < SIZE)  nb_hit = nb_hit | mask[row + 5'd1][col];
    if (col != 5'd0)        nb_hit = nb_hit | mask[row][col - 5'd1];
    if (col + 5'd1 < SIZE)  nb_hit = nb_hit | mask[row][col + 5'd1];
  end

  assign join_now     = (state == ST_GROW) && !mask[row][col] &&
                        (BOARD[row][col] == region_color) && nb_hit;
  assign pass_changed = changed | join_now;
  assign grow_done    = (state == ST_GROW) && last_cell && !pass_changed;

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    lfsr_load  = 1'b0;
    lfsr_step  = 1'b0;
    if (start) begin
      state_next = ST_FILL;
      lfsr_load  = 1'b1;
    end else begin
      case (state)
        ST_FILL: begin
          lfsr_step = 1'b1;
          if (last_cell) state_next = ST_GROW;
        end
        ST_GROW: begin
          if (grow_done) state_next = (full || moves_spent) ? ST_OVER : ST_READY;
        end
        ST_READY:   if (move_ok) state_next = ST_RECOLOR;
        ST_RECOLOR: state_next = ST_GROW;
        default:    state_next = state;
      endcase
    end
  end

  assign busy      = (state == ST_FILL) || (state == ST_GROW) || (state == ST_RECOLOR);
  assign dbg_state = state;
  assign dbg_mask  = mask;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      BOARD       <= '0;
      mask        <= '0;
      SIZE        <= '0;
      row         <= '0;
      col         <= '0;
      changed     <= 1'b0;
      pop_count   <= '0;
      move_count  <= '0;
      move_color  <= '0;
      initialized <= 1'b0;
      won         <= 1'b0;
      lost        <= 1'b0;
    end else if (start) begin
      // Whole board cleared here so cells outside the new SIZE read as 0.
      BOARD       <= '0;
      mask        <= '0;
      SIZE        <= size_clamped;
      row         <= '0;
      col         <= '0;
      changed     <= 1'b0;
      pop_count   <= '0;
      move_count  <= '0;
      initialized <= 1'b0;
      won         <= 1'b0;
      lost        <= 1'b0;
    end else begin
      if (state == ST_FILL || state == ST_GROW) begin
        if (col == SIZE - 5'd1) begin
          col <= '0;
          row <= last_cell ? 5'd0 : row + 5'd1;
        end else begin
          col <= col + 5'd1;
        end
      end
      case (state)
        ST_FILL: begin
          BOARD[row][col] <= fill_color;
          if (last_cell) begin
            mask[0][0] <= 1'b1;
            pop_count  <= 10'd1;
          end
        end
        ST_GROW: begin
          if (join_now) begin
            mask[row][col] <= 1'b1;
            pop_count      <= pop_count + 10'd1;
          end
          changed <= last_cell ? 1'b0 : pass_changed;
          if (grow_done) begin
            if (full)             won         <= 1'b1;
            else if (moves_spent) lost        <= 1'b1;
            else                  initialized <= 1'b1;
          end
        end
        ST_READY: begin
          if (move_ok) begin
            move_color <= color_sel;
            if (move_count != 5'd31) move_count <= move_count + 5'd1;
          end
        end
        ST_RECOLOR: begin
          for (int r = 0; r < MAX_SIZE; r++)
            for (int c = 0; c < MAX_SIZE; c++)
              if (mask[r][c]) BOARD[r][c] <= move_color;
        end
        default: ;
      endcase
    end
  end

endmodule
